// File: rtl/rf_alloc_unit.sv
// rtl/rf_alloc_unit.sv - register-file block allocator: first-fit scan, per-warp base/size table, exit-driven free
//
// Owns the RF block bitmap shared by all hardware warps. Allocation requests
// scan the bitmap one start position per cycle and record base/size per warp.
// Exits are queued as pending bits and released one warp per FREE cycle;
// pending exits always run before a pending allocation.
// Optional feature macro: RAU_FREECNT_EN adds an incrementally maintained
// free-block counter (FreeCnt_RAU_TM) and early rejection of oversize requests.
module rf_alloc_unit #(
   parameter int NUM_WARPS  = 8,
   parameter int NUM_BLOCKS = 8,
   parameter int WID_W      = 3,
   parameter int BLK_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             AlloEN_TM_RAU,
   input  logic [WID_W-1:0] HWWarp_TM_RAU,
   input  logic [BLK_W-1:0] Nreq_TM_RAU,
   input  logic             ExitEN_IB_RAU,
   input  logic [WID_W-1:0] ExitWarpID_IB_RAU,
   input  logic [WID_W-1:0] Query_OC_RAU,
   output logic             Available_RAU_TM,
   output logic             AlloStall_RAU_IB,
   output logic             AlloDone_RAU_TM,
   output logic             AlloFail_RAU_TM,
   output logic [BLK_W-1:0] Base_RAU_OC,
   output logic [BLK_W-1:0] Size_RAU_OC,
   output logic             QValid_RAU_OC
`ifdef RAU_FREECNT_EN
  ,output logic [BLK_W:0]   FreeCnt_RAU_TM
`endif
);

   localparam int CNT_W = BLK_W + 1;
   localparam int MW    = 2 * NUM_BLOCKS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FREE  = 2'd1,
      S_ALLOC = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [NUM_BLOCKS-1:0] bitmap_q, bitmap_d;
   logic [NUM_WARPS-1:0]  valid_q, valid_d;
   logic [BLK_W-1:0]      base_q [NUM_WARPS];
   logic [BLK_W-1:0]      base_d [NUM_WARPS];
   logic [BLK_W-1:0]      size_q [NUM_WARPS];
   logic [BLK_W-1:0]      size_d [NUM_WARPS];
   logic [NUM_WARPS-1:0]  exit_pend_q, exit_pend_d;
   logic                  alloc_pend_q, alloc_pend_d;
   logic [WID_W-1:0]      req_wid_q, req_wid_d;
   logic [CNT_W-1:0]      req_n_q, req_n_d;
   logic [CNT_W-1:0]      scan_s_q, scan_s_d;
   logic                  available_q, available_d;
   logic                  stall_q, stall_d;
   logic                  done_q, done_d;
   logic                  fail_q, fail_d;

`ifdef RAU_FREECNT_EN
   logic [CNT_W-1:0]      free_cnt_q, free_cnt_d;
`endif

   logic                  alloc_acc;
   logic                  exit_any;
   logic [WID_W-1:0]      free_wid;
   logic [MW-1:0]         scan_mask;
   logic [MW-1:0]         scan_occ;
   logic [NUM_BLOCKS-1:0] free_mask;
   logic                  scan_hit;
   logic                  scan_last;
   logic                  req_busy;
   logic                  cnt_short;
   logic                  alloc_fail;
   logic                  alloc_done;

   // Decode: request acceptance, lowest pending exit, scan window test and free window
   always_comb begin
      alloc_acc = AlloEN_TM_RAU && available_q;
      exit_any  = (exit_pend_q != '0) || ExitEN_IB_RAU;

      free_wid = '0;
      for (int i = NUM_WARPS - 1; i >= 0; i--) begin
         if (exit_pend_q[i]) begin
            free_wid = WID_W'(i);
         end
      end

      // Window [s, s+n) over a map padded with used blocks past the top
      for (int i = 0; i < MW; i++) begin
         scan_mask[i] = (i >= int'(scan_s_q)) && (i < int'(scan_s_q) + int'(req_n_q));
      end
      scan_occ  = {{NUM_BLOCKS{1'b1}}, bitmap_q};
      scan_hit  = (scan_occ & scan_mask) == '0;
      scan_last = ({1'b0, scan_s_q} + {1'b0, req_n_q}) >= (CNT_W + 1)'(NUM_BLOCKS);
      req_busy  = valid_q[req_wid_q];

`ifdef RAU_FREECNT_EN
      cnt_short = req_n_q > free_cnt_q;
`else
      cnt_short = 1'b0;
`endif

      alloc_fail = (state_q == S_ALLOC) && (req_busy || cnt_short || (!scan_hit && scan_last));
      alloc_done = (state_q == S_ALLOC) && !req_busy && !cnt_short && scan_hit;

      for (int i = 0; i < NUM_BLOCKS; i++) begin
         free_mask[i] = (i >= int'(base_q[free_wid])) &&
                        (i <= int'(base_q[free_wid]) + int'(size_q[free_wid]));
      end
   end

   // Next-state: exits first, then a pending or newly accepted allocation
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (exit_any) begin
               state_d = S_FREE;
            end else if (alloc_pend_q || alloc_acc) begin
               state_d = S_ALLOC;
            end
         end
         S_FREE: begin
            state_d = S_IDLE;
         end
         S_ALLOC: begin
            if (alloc_done || alloc_fail) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath: request latch, pending exits, bitmap/table updates, scan position
   always_comb begin
      bitmap_d     = bitmap_q;
      valid_d      = valid_q;
      base_d       = base_q;
      size_d       = size_q;
      exit_pend_d  = exit_pend_q;
      alloc_pend_d = alloc_pend_q;
      req_wid_d    = req_wid_q;
      req_n_d      = req_n_q;
      scan_s_d     = scan_s_q;
`ifdef RAU_FREECNT_EN
      free_cnt_d   = free_cnt_q;
`endif

      if (alloc_acc) begin
         alloc_pend_d = 1'b1;
         req_wid_d    = HWWarp_TM_RAU;
         req_n_d      = {1'b0, Nreq_TM_RAU} + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            scan_s_d = '0;
         end
         S_FREE: begin
            exit_pend_d[free_wid] = 1'b0;
            if (valid_q[free_wid]) begin
               bitmap_d          = bitmap_q & ~free_mask;
               valid_d[free_wid] = 1'b0;
               base_d[free_wid]  = '0;
               size_d[free_wid]  = '0;
`ifdef RAU_FREECNT_EN
               free_cnt_d = free_cnt_q + {1'b0, size_q[free_wid]} + CNT_W'(1);
`endif
            end
         end
         S_ALLOC: begin
            if (alloc_done) begin
               bitmap_d           = bitmap_q | scan_mask[NUM_BLOCKS-1:0];
               valid_d[req_wid_q] = 1'b1;
               base_d[req_wid_q]  = scan_s_q[BLK_W-1:0];
               size_d[req_wid_q]  = BLK_W'(req_n_q - CNT_W'(1));
               alloc_pend_d       = 1'b0;
`ifdef RAU_FREECNT_EN
               free_cnt_d = free_cnt_q - req_n_q;
`endif
            end else if (alloc_fail) begin
               alloc_pend_d = 1'b0;
            end else begin
               scan_s_d = scan_s_q + CNT_W'(1);
            end
         end
         default: begin
            scan_s_d = '0;
         end
      endcase

      // A new exit always lands, even for the warp being freed this cycle
      if (ExitEN_IB_RAU) begin
         exit_pend_d[ExitWarpID_IB_RAU] = 1'b1;
      end
   end

   // Outputs: handshake/stall levels follow the next state, result pulses last one cycle
   always_comb begin
      available_d = (state_d == S_IDLE) && !alloc_pend_d;
      stall_d     = (state_d != S_IDLE);
      done_d      = alloc_done;
      fail_d      = alloc_fail;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Map, warp table, pending flags and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bitmap_q     <= '0;
         valid_q      <= '0;
         for (int i = 0; i < NUM_WARPS; i++) begin
            base_q[i] <= '0;
            size_q[i] <= '0;
         end
         exit_pend_q  <= '0;
         alloc_pend_q <= 1'b0;
         req_wid_q    <= '0;
         req_n_q      <= '0;
         scan_s_q     <= '0;
         available_q  <= 1'b1;
         stall_q      <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
`ifdef RAU_FREECNT_EN
         free_cnt_q   <= CNT_W'(NUM_BLOCKS);
`endif
      end else begin
         bitmap_q     <= bitmap_d;
         valid_q      <= valid_d;
         base_q       <= base_d;
         size_q       <= size_d;
         exit_pend_q  <= exit_pend_d;
         alloc_pend_q <= alloc_pend_d;
         req_wid_q    <= req_wid_d;
         req_n_q      <= req_n_d;
         scan_s_q     <= scan_s_d;
         available_q  <= available_d;
         stall_q      <= stall_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
`ifdef RAU_FREECNT_EN
         free_cnt_q   <= free_cnt_d;
`endif
      end
   end

   assign Available_RAU_TM = available_q;
   assign AlloStall_RAU_IB = stall_q;
   assign AlloDone_RAU_TM  = done_q;
   assign AlloFail_RAU_TM  = fail_q;
   assign Base_RAU_OC      = base_q[Query_OC_RAU];
   assign Size_RAU_OC      = size_q[Query_OC_RAU];
   assign QValid_RAU_OC    = valid_q[Query_OC_RAU];
`ifdef RAU_FREECNT_EN
   assign FreeCnt_RAU_TM   = free_cnt_q;
`endif

endmodule
